// File: rtl/stopwatch_ctrl.sv
// Run/pause/done sequencer for a two-digit counter: divides clk into count ticks,
// shadows the count so it halts at MAX_COUNT, and emits registered enable/clear pulses.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_COUNT = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [6:0] count_val,
  output logic [1:0] state,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]     CNT_MAX  = 7'(MAX_COUNT);

  state_t        state_q, state_n;
  logic [PW-1:0] presc_q, presc_n;
  logic [6:0]    count_n;
  logic          en_n, clr_n;
  logic          start_q, clear_q;
  logic          start_press, clear_press, tick;

  assign start_press = btn_start & ~start_q;
  assign clear_press = btn_clear & ~clear_q;
  assign tick        = (state_q == RUN) && (presc_q == PRE_LAST);

  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    count_n = count_val;
    en_n    = 1'b0;
    clr_n   = 1'b0;
    if (clear_press) begin
      state_n = IDLE;
      presc_n = '0;
      count_n = '0;
      clr_n   = 1'b1;
    end else begin
      if (state_q == RUN) begin
        if (tick) begin
          presc_n = '0;
          count_n = count_val + 7'd1;
          en_n    = 1'b1;
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
      case (state_q)
        IDLE: begin
          if (start_press) begin
            state_n = RUN;
            presc_n = '0;
          end
        end
        // Reaching terminal count outranks a simultaneous pause request.
        RUN: begin
          if (tick && (count_val + 7'd1 == CNT_MAX)) state_n = DONE;
          else if (start_press)                      state_n = PAUSE;
        end
        PAUSE: begin
          if (start_press) state_n = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      count_val <= '0;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      done      <= 1'b0;
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      presc_q   <= presc_n;
      count_val <= count_n;
      cnt_en    <= en_n;
      cnt_clr   <= clr_n;
      done      <= (state_n == DONE);
      start_q   <= btn_start;
      clear_q   <= btn_clear;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl with TICK_DIV=4, MAX_COUNT=5; every cnt_en pulse
// is matched against a queue of expected count values pushed by the scenario tasks.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       cnt_en, cnt_clr, done;
  logic [6:0] count_val;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];

  stopwatch_ctrl #(.TICK_DIV(4), .MAX_COUNT(5)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_clear(btn_clear),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .count_val(count_val),
    .state(state), .done(done)
  );

  always #10 clk = ~clk;

  // Every tick must correspond to an expected count pushed by the stimulus.
  always @(negedge clk) begin
    if (cnt_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tick_unexpected: cnt_en=1 count_val=%0d, required no tick", count_val);
      end else begin
        automatic logic [6:0] e = exp_q.pop_front();
        if (count_val !== e) begin
          failures++;
          $display("FAIL tick_count: count_val=%0d, required %0d", count_val, e);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    cycle();
    btn_clear = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) cycle();
    checks += 5;
    if (state !== 2'd0)     begin failures++; $display("FAIL reset_state: %0d, required 0", state); end
    if (cnt_en !== 1'b0)    begin failures++; $display("FAIL reset_cnt_en: %b, required 0", cnt_en); end
    if (cnt_clr !== 1'b0)   begin failures++; $display("FAIL reset_cnt_clr: %b, required 0", cnt_clr); end
    if (count_val !== 7'd0) begin failures++; $display("FAIL reset_count: %0d, required 0", count_val); end
    if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: %b, required 0", done); end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_full_run();
    btn_start = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(7'(k));
    cycle();
    btn_start = 1'b0;
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL run_enter: state=%0d, required 1", state); end
    for (int i = 1; i <= 24; i++) begin
      automatic logic e = (i % 4 == 0) && (i <= 20);
      cycle();
      checks++;
      if (cnt_en !== e) begin
        failures++;
        $display("FAIL run_cnt_en cycle %0d: %b, required %b", i, cnt_en, e);
      end
    end
    checks += 3;
    if (state !== 2'd3)     begin failures++; $display("FAIL run_done_state: %0d, required 3", state); end
    if (done !== 1'b1)      begin failures++; $display("FAIL run_done_flag: %b, required 1", done); end
    if (count_val !== 7'd5) begin failures++; $display("FAIL run_final_count: %0d, required 5", count_val); end
  endtask

  task automatic test_done_buttons();
    btn_start = 1'b1;
    cycle();
    btn_start = 1'b0;
    cycle();
    checks += 2;
    if (state !== 2'd3)     begin failures++; $display("FAIL done_start_state: %0d, required 3", state); end
    if (count_val !== 7'd5) begin failures++; $display("FAIL done_start_count: %0d, required 5", count_val); end
    btn_clear = 1'b1;
    cycle();
    btn_clear = 1'b0;
    checks += 4;
    if (cnt_clr !== 1'b1)   begin failures++; $display("FAIL done_clear_pulse: %b, required 1", cnt_clr); end
    if (state !== 2'd0)     begin failures++; $display("FAIL done_clear_state: %0d, required 0", state); end
    if (count_val !== 7'd0) begin failures++; $display("FAIL done_clear_count: %0d, required 0", count_val); end
    if (done !== 1'b0)      begin failures++; $display("FAIL done_clear_done: %b, required 0", done); end
    cycle();
    checks++;
    if (cnt_clr !== 1'b0) begin failures++; $display("FAIL done_clear_width: %b, required 0", cnt_clr); end
  endtask

  task automatic test_pause_resume();
    btn_start = 1'b1;
    exp_q.push_back(7'd1);
    cycle();
    btn_start = 1'b0;
    repeat (5) cycle();
    btn_start = 1'b1;
    cycle();
    btn_start = 1'b0;
    checks += 2;
    if (state !== 2'd2)     begin failures++; $display("FAIL pause_state: %0d, required 2", state); end
    if (count_val !== 7'd1) begin failures++; $display("FAIL pause_count: %0d, required 1", count_val); end
    repeat (20) cycle();
    checks += 2;
    if (state !== 2'd2)     begin failures++; $display("FAIL pause_hold_state: %0d, required 2", state); end
    if (count_val !== 7'd1) begin failures++; $display("FAIL pause_hold_count: %0d, required 1", count_val); end
    btn_start = 1'b1;
    exp_q.push_back(7'd2);
    cycle();
    btn_start = 1'b0;
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL resume_state: %0d, required 1", state); end
    cycle();
    checks++;
    if (cnt_en !== 1'b0) begin failures++; $display("FAIL resume_early_tick: %b, required 0", cnt_en); end
    cycle();
    checks += 2;
    if (cnt_en !== 1'b1)    begin failures++; $display("FAIL resume_tick: %b, required 1", cnt_en); end
    if (count_val !== 7'd2) begin failures++; $display("FAIL resume_count: %0d, required 2", count_val); end
    press_clear();
  endtask

  task automatic test_start_clear_same();
    btn_start = 1'b1;
    for (int k = 1; k <= 3; k++) exp_q.push_back(7'(k));
    cycle();
    btn_start = 1'b0;
    repeat (12) cycle();
    checks++;
    if (count_val !== 7'd3) begin failures++; $display("FAIL both_precount: %0d, required 3", count_val); end
    btn_start = 1'b1;
    btn_clear = 1'b1;
    cycle();
    btn_start = 1'b0;
    btn_clear = 1'b0;
    checks += 3;
    if (cnt_clr !== 1'b1)   begin failures++; $display("FAIL both_clr: %b, required 1", cnt_clr); end
    if (state !== 2'd0)     begin failures++; $display("FAIL both_state: %0d, required 0", state); end
    if (count_val !== 7'd0) begin failures++; $display("FAIL both_count: %0d, required 0", count_val); end
    cycle();
    checks += 2;
    if (cnt_clr !== 1'b0) begin failures++; $display("FAIL both_clr_width: %b, required 0", cnt_clr); end
    if (state !== 2'd0)   begin failures++; $display("FAIL both_after_state: %0d, required 0", state); end
  endtask

  task automatic test_held_start();
    btn_start = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(7'(k));
    cycle();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL held_enter: %0d, required 1", state); end
    repeat (2) cycle();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL held_no_pause: %0d, required 1", state); end
    repeat (47) cycle();
    btn_start = 1'b0;
    checks += 2;
    if (state !== 2'd3)     begin failures++; $display("FAIL held_final_state: %0d, required 3", state); end
    if (count_val !== 7'd5) begin failures++; $display("FAIL held_final_count: %0d, required 5", count_val); end
    press_clear();
  endtask

  task automatic test_reset_mid_run();
    btn_start = 1'b1;
    cycle();
    btn_start = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    checks += 5;
    if (cnt_en !== 1'b0)    begin failures++; $display("FAIL rst_run_cnt_en: %b, required 0", cnt_en); end
    if (cnt_clr !== 1'b0)   begin failures++; $display("FAIL rst_run_cnt_clr: %b, required 0", cnt_clr); end
    if (state !== 2'd0)     begin failures++; $display("FAIL rst_run_state: %0d, required 0", state); end
    if (count_val !== 7'd0) begin failures++; $display("FAIL rst_run_count: %0d, required 0", count_val); end
    if (done !== 1'b0)      begin failures++; $display("FAIL rst_run_done: %b, required 0", done); end
    reset = 1'b0;
    repeat (6) cycle();
    checks += 2;
    if (state !== 2'd0)  begin failures++; $display("FAIL rst_after_state: %0d, required 0", state); end
    if (cnt_en !== 1'b0) begin failures++; $display("FAIL rst_after_cnt_en: %b, required 0", cnt_en); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_done_buttons();
    test_pause_resume();
    test_start_clear_same();
    test_held_start();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL ticks_missing: %0d expected ticks never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
